// File: rtl/gc_joybus_pkg.sv
// Shared types and constants for the GameCube joybus command transmitter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gc_joybus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  // One bit per quarter, quarter 0 in the MSB; 1 means pull the line low.
  localparam logic [3:0] QPAT_ZERO = 4'b1110;
  localparam logic [3:0] QPAT_ONE  = 4'b1000;

  // Common controller commands, left-justified as sent.
  localparam logic [7:0]  CMD_STATUS = 8'h00;
  localparam logic [23:0] CMD_POLL   = 24'h400302;

  // Line level (1 = drive low) for a given data bit value and quarter.
  function automatic logic qpat_low(input logic bit_val, input logic [1:0] q);
    logic [3:0] pat;
    pat = bit_val ? QPAT_ONE : QPAT_ZERO;
    return pat[2'd3 - q];
  endfunction

endpackage

// File: rtl/gc_joybus_tx_timer.sv
// Quarter-bit timer: prescaler 0..QUARTER_CYCLES-1 plus a 0..3 quarter counter.
// Latency: clear takes effect on the next cycle; counts only while run is high.
// Backpressure: none; free-running while enabled.
module gc_quarter_timer #(
  parameter int QUARTER_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       run,
  output logic [1:0] q_idx,
  output logic       pre_last,
  output logic       pre_pen,
  output logic       q_last
);

  localparam int PRE_W = (QUARTER_CYCLES > 1) ? $clog2(QUARTER_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(QUARTER_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_PEN = PRE_W'(QUARTER_CYCLES - 2);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [1:0]       q_q, q_d;

  assign pre_last = (pre_q == PRE_MAX);
  assign pre_pen  = (pre_q == PRE_PEN);
  assign q_last   = pre_last && (q_q == 2'd3);
  assign q_idx    = q_q;

  // Next prescaler / quarter value: restart on clear, step while running.
  always_comb begin
    pre_d = pre_q;
    q_d   = q_q;
    if (clear) begin
      pre_d = '0;
      q_d   = 2'd0;
    end else if (run) begin
      if (pre_last) begin
        pre_d = '0;
        q_d   = q_q + 2'd1;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  // Timer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      q_q   <= 2'd0;
    end else begin
      pre_q <= pre_d;
      q_q   <= q_d;
    end
  end

endmodule

// File: rtl/gc_joybus_tx.sv
// Joybus command transmitter: serialises 1..MAX_BYTES bytes MSB first plus stop bit.
// Latency: line driven low the cycle after an accepted start; done at end of stop bit.
// Backpressure: start ignored while busy; bad cmd_len rejected with a one-cycle err.
module gc_joybus_tx
  import gc_joybus_pkg::*;
#(
  parameter int QUARTER_CYCLES = 100,
  parameter int MAX_BYTES      = 3,
  parameter int LEN_W          = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*MAX_BYTES-1:0] cmd_data,
  input  logic [LEN_W-1:0]       cmd_len,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   tx_en,
  output logic                   tx_low
);

  localparam int DW    = 8 * MAX_BYTES;
  localparam int BIT_W = $clog2(DW);

  state_t           state_q, state_d;
  logic [DW-1:0]    data_q, data_d;
  logic [BIT_W-1:0] last_bit_q, last_bit_d;
  logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             tx_en_q, tx_en_d;
  logic             tx_low_q, tx_low_d;

  logic       len_ok;
  logic       accept;
  logic [1:0] q_idx;
  logic [1:0] q_next;
  logic       pre_last;
  logic       pre_pen;
  logic       q_last;

  assign len_ok = (cmd_len != '0) && (cmd_len <= LEN_W'(MAX_BYTES));
  assign accept = (state_q == IDLE) && start && len_ok;

  gc_quarter_timer #(
    .QUARTER_CYCLES(QUARTER_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .run     (state_q != IDLE),
    .q_idx   (q_idx),
    .pre_last(pre_last),
    .pre_pen (pre_pen),
    .q_last  (q_last)
  );

  // Outputs are registered, so they are computed for the quarter the next cycle lands in.
  assign q_next = pre_last ? (q_idx + 2'd1) : q_idx;

  // Next-state and next-output logic for the transmit FSM.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    last_bit_d = last_bit_q;
    bit_idx_d  = bit_idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    tx_en_d    = tx_en_q;
    tx_low_d   = tx_low_q;
    case (state_q)
      IDLE: begin
        busy_d   = 1'b0;
        tx_en_d  = 1'b0;
        tx_low_d = 1'b0;
        if (start) begin
          if (len_ok) begin
            state_d    = DATA;
            data_d     = cmd_data;
            last_bit_d = BIT_W'({cmd_len, 3'b000} - (LEN_W + 3)'(1));
            bit_idx_d  = '0;
            busy_d     = 1'b1;
            tx_en_d    = 1'b1;
            tx_low_d   = 1'b1;  // quarter 0 of every bit is low
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DATA: begin
        busy_d  = 1'b1;
        tx_en_d = 1'b1;
        if (q_last) begin
          // Next cycle is quarter 0 of either the next data bit or the stop bit.
          bit_idx_d = bit_idx_q + BIT_W'(1);
          data_d    = data_q << 1;
          tx_low_d  = 1'b1;
          if (bit_idx_q == last_bit_q) begin
            state_d = STOP;
          end
        end else begin
          tx_low_d = qpat_low(data_q[DW-1], q_next);
        end
      end
      STOP: begin
        if (q_last) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          tx_en_d  = 1'b0;
          tx_low_d = 1'b0;
        end else begin
          busy_d   = 1'b1;
          // Only quarter 0 is driven; afterwards the bus belongs to the reply.
          tx_en_d  = (q_next == 2'd0);
          tx_low_d = (q_next == 2'd0);
          done_d   = (q_idx == 2'd3) && pre_pen;
        end
      end
      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        tx_en_d  = 1'b0;
        tx_low_d = 1'b0;
      end
    endcase
  end

  // FSM state, latched command and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      last_bit_q <= '0;
      bit_idx_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_low_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      last_bit_q <= last_bit_d;
      bit_idx_q  <= bit_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tx_en_q    <= tx_en_d;
      tx_low_q   <= tx_low_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign tx_en  = tx_en_q;
  assign tx_low = tx_low_q;

endmodule
